// File: rtl/addmin16_arb.sv
// Two-requester round-robin 16-bit add/subtract unit sharing one 4-bit slice, LSB nibble first.
// Define ADDMIN16_ARB_OVF_EN to add the signed-overflow output ovf.
module addmin16_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        op_a,
  input  logic        op_b,
  input  logic [15:0] x_a,
  input  logic [15:0] y_a,
  input  logic [15:0] x_b,
  input  logic [15:0] y_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] result,
`ifdef ADDMIN16_ARB_OVF_EN
  output logic        ovf,
`endif
  output logic        carry
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        prio_q, prio_d;   // 0: A holds priority, 1: B holds priority
  logic        owner_q, owner_d;
  logic        op_q, op_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic        busy_q, busy_d, done_q, done_d, done_id_q, done_id_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
`ifdef ADDMIN16_ARB_OVF_EN
  logic        ovf_q, ovf_d;
`endif

  logic        grant_b;
  logic        cin;
  logic [3:0]  x_nib, y_nib;
  logic [4:0]  slice;

  // The single shared nibble slice; bit 4 is carry-out (add) or borrow-out (subtract).
  always_comb begin
    x_nib = x_q[{idx_q, 2'b00} +: 4];
    y_nib = y_q[{idx_q, 2'b00} +: 4];
    cin   = (idx_q == 2'd0) ? 1'b0 : carry_q;
    if (op_q) begin
      slice = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, cin};
    end else begin
      slice = {1'b0, x_nib} - {1'b0, y_nib} - {4'b0000, cin};
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    carry_d   = carry_q;
`ifdef ADDMIN16_ARB_OVF_EN
    ovf_d     = ovf_q;
`endif
    grant_b   = req_b & (~req_a | prio_q);

    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          // Priority only rotates when both requesters contend.
          if (req_a && req_b) prio_d = ~grant_b;
          state_d = StCalc;
          idx_d   = 2'd0;
          owner_d = grant_b;
          op_d    = grant_b ? op_b : op_a;
          x_d     = grant_b ? x_b : x_a;
          y_d     = grant_b ? y_b : y_a;
          ack_a_d = ~grant_b;
          ack_b_d = grant_b;
          busy_d  = 1'b1;
        end
      end
      StCalc: begin
        result_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d   = StDone;
          done_d    = 1'b1;
          done_id_d = owner_q;
`ifdef ADDMIN16_ARB_OVF_EN
          ovf_d = op_q ? ((x_q[15] == y_q[15]) && (slice[3] != x_q[15]))
                       : ((x_q[15] != y_q[15]) && (slice[3] != x_q[15]));
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      op_q      <= 1'b0;
      x_q       <= 16'h0000;
      y_q       <= 16'h0000;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= 16'h0000;
      carry_q   <= 1'b0;
`ifdef ADDMIN16_ARB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
`ifdef ADDMIN16_ARB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign carry   = carry_q;
`ifdef ADDMIN16_ARB_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
